// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory-op encodings, FSM states
// and the access-legality rule.
package lsu_pkg;

  typedef enum logic [2:0] {
    OP_B    = 3'b000,
    OP_H    = 3'b001,
    OP_W    = 3'b010,
    OP_BU   = 3'b100,
    OP_HU   = 3'b101,
    OP_NONE = 3'b111
  } mem_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_e;

  // Encodings 011 and 110 are unassigned, so they are rejected like OP_NONE.
  function automatic logic is_misaligned(input mem_op_e op, input logic wr,
                                         input logic [1:0] a);
    case (op)
      OP_B:    is_misaligned = 1'b0;
      OP_H:    is_misaligned = a[0];
      OP_W:    is_misaligned = (a != 2'b00);
      OP_BU:   is_misaligned = wr;
      OP_HU:   is_misaligned = wr | a[0];
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replication, load lane extract and
// sign/zero extension. The data bus carries four byte lanes.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mem_op_e          op,
  input  logic [1:0]       addr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       wmask,
  output logic [WIDTH-1:0] wdata_rep,
  output logic [WIDTH-1:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wmask     = 4'b0000;
    wdata_rep = wdata;
    case (op)
      OP_B, OP_BU: begin
        wmask     = 4'b0001 << addr_lo;
        wdata_rep = {(WIDTH/8){wdata[7:0]}};
      end
      OP_H, OP_HU: begin
        wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {(WIDTH/16){wdata[15:0]}};
      end
      OP_W:    wmask = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = mem_rdata[7:0];
    case (addr_lo)
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      2'd3:    byte_sel = mem_rdata[31:24];
      default: ;
    endcase
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (op)
      OP_B:    rdata_ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      OP_BU:   rdata_ext = {{(WIDTH-8){1'b0}}, byte_sel};
      OP_H:    rdata_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
      OP_HU:   rdata_ext = {{(WIDTH-16){1'b0}}, half_sel};
      OP_W:    rdata_ext = mem_rdata;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one access per instruction, runs a req/gnt then
// rvalid handshake against a word-addressed memory and pulses done on completion.
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_wr,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] rdata,
  output logic             misalign,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [3:0]       mem_wmask,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic             mem_gnt,
  input  logic             mem_rvalid,
  input  logic [WIDTH-1:0] mem_rdata
);

  state_e           state;
  mem_op_e          op_q;
  logic             wr_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [3:0]       wmask;
  logic [WIDTH-1:0] rdata_ext;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .wmask     (wmask),
    .wdata_rep (mem_wdata),
    .rdata_ext (rdata_ext)
  );

  assign stall     = req_valid & (state != S_RESP);
  assign mem_addr  = {addr_q[WIDTH-1:2], 2'b00};
  assign mem_we    = mem_req & wr_q;
  assign mem_wmask = mem_we ? wmask : 4'b0000;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= OP_B;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      done     <= 1'b0;
      misalign <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            op_q    <= mem_op_e'(req_op);
            wr_q    <= req_wr;
            addr_q  <= addr;
            wdata_q <= wdata;
            rdata   <= '0;
            if (is_misaligned(mem_op_e'(req_op), req_wr, addr[1:0])) begin
              misalign <= 1'b1;
              done     <= 1'b1;
              state    <= S_RESP;
            end else begin
              misalign <= 1'b0;
              mem_req  <= 1'b1;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (wr_q) begin
              done  <= 1'b1;
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (mem_rvalid) begin
            rdata <= rdata_ext;
            done  <= 1'b1;
            state <= S_RESP;
          end
        end
        default: begin
          misalign <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, loads, misaligned accesses, slow handshakes
// and reset abort, against hand-computed expectations.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr;
  logic [2:0]  req_op;
  logic [31:0] addr, wdata;
  logic        stall, done, misalign;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;

  int checks   = 0;
  int failures = 0;

  int          lat, req_cnt, done_cnt;
  logic [3:0]  mk;
  logic [31:0] mwd, madr, rd;
  logic        we, mis, sok;

  always #5 clk = ~clk;

  lsu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_wr     (req_wr),
    .req_op     (req_op),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .rdata      (rdata),
    .misalign   (misalign),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wmask  (mem_wmask),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one access from IDLE and acts as the memory: grants after gnt_dly
  // request cycles, returns data gnt-to-rvalid rv_dly cycles later.
  task automatic do_access(input logic w, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input int gnt_dly, input int rv_dly,
                           input logic [31:0] mrd);
    int   req_n   = 0;
    int   wait_n  = 0;
    logic granted = 1'b0;
    lat = -1; done_cnt = 0; sok = 1'b1;
    mk = 4'hx; mwd = 'x; madr = 'x; we = 1'bx; rd = 'x; mis = 1'bx;
    req_valid = 1'b1; req_wr = w; req_op = op; addr = a; wdata = wd;
    mem_rdata = mrd; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    if (stall !== 1'b1) sok = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (done === 1'b1) begin
        lat = c; done_cnt++; rd = rdata; mis = misalign;
        if (stall !== 1'b0) sok = 1'b0;
        break;
      end
      if (stall !== 1'b1) sok = 1'b0;
      if (mem_req === 1'b1) begin
        if (req_n == 0) begin
          mk = mem_wmask; mwd = mem_wdata; madr = mem_addr; we = mem_we;
        end
        if (req_n == gnt_dly) begin
          mem_gnt = 1'b1;
          granted = 1'b1;
        end
        req_n++;
      end else if (granted) begin
        if (wait_n == rv_dly) mem_rvalid = 1'b1;
        wait_n++;
      end
    end
    req_valid = 1'b0;
    step();
    if (done === 1'b1) done_cnt++;
    req_cnt = req_n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_op = OP_W;
    addr = '0; wdata = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    step(); step();
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_mem_req_we got=%b%b exp=00", mem_req, mem_we); end
    checks++; if (mem_wmask !== 4'b0000) begin failures++; $display("FAIL reset_wmask got=%b exp=0000", mem_wmask); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_store();
    do_access(1'b1, OP_W, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    checks++; if (lat !== 2) begin failures++; $display("FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (mk !== 4'b1111) begin failures++; $display("FAIL sw_wmask got=%b exp=1111", mk); end
    checks++; if (madr !== 32'h100) begin failures++; $display("FAIL sw_addr got=%h exp=00000100", madr); end
    checks++; if (mwd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_wdata got=%h exp=deadbeef", mwd); end
    checks++; if (we !== 1'b1) begin failures++; $display("FAIL sw_we got=%b exp=1", we); end
    checks++; if (done_cnt !== 1 || mis !== 1'b0) begin failures++; $display("FAIL sw_done got=%0d/%b exp=1/0", done_cnt, mis); end

    do_access(1'b1, OP_H, 32'h102, 32'h00001234, 0, 0, 32'h0);
    checks++; if (mk !== 4'b1100) begin failures++; $display("FAIL sh_wmask got=%b exp=1100", mk); end
    checks++; if (mwd !== 32'h12341234) begin failures++; $display("FAIL sh_wdata got=%h exp=12341234", mwd); end
    checks++; if (madr !== 32'h100) begin failures++; $display("FAIL sh_addr got=%h exp=00000100", madr); end

    do_access(1'b1, OP_B, 32'h101, 32'h000000AB, 1, 0, 32'h0);
    checks++; if (mk !== 4'b0010) begin failures++; $display("FAIL sb_wmask got=%b exp=0010", mk); end
    checks++; if (mwd !== 32'hABABABAB) begin failures++; $display("FAIL sb_wdata got=%h exp=abababab", mwd); end
    checks++; if (lat !== 3 || req_cnt !== 2) begin failures++; $display("FAIL sb_gnt_wait got=%0d/%0d exp=3/2", lat, req_cnt); end
  endtask

  task automatic test_load();
    do_access(1'b0, OP_B, 32'h103, 32'h0, 0, 0, 32'h80FF7F01);
    checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", rd); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL lb_latency got=%0d exp=3", lat); end
    checks++; if (we !== 1'b0 || mk !== 4'b0000) begin failures++; $display("FAIL lb_we_mask got=%b/%b exp=0/0000", we, mk); end

    do_access(1'b0, OP_BU, 32'h103, 32'h0, 0, 0, 32'h80FF7F01);
    checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", rd); end

    do_access(1'b0, OP_H, 32'h102, 32'h0, 0, 0, 32'h80FF7F01);
    checks++; if (rd !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff80ff", rd); end

    do_access(1'b0, OP_HU, 32'h100, 32'h0, 0, 0, 32'h80FF7F01);
    checks++; if (rd !== 32'h00007F01) begin failures++; $display("FAIL lhu_rdata got=%h exp=00007f01", rd); end

    do_access(1'b0, OP_B, 32'h101, 32'h0, 0, 0, 32'h80FF7F01);
    checks++; if (rd !== 32'h0000007F) begin failures++; $display("FAIL lb_pos_rdata got=%h exp=0000007f", rd); end
  endtask

  task automatic test_misalign();
    do_access(1'b0, OP_H, 32'h101, 32'h0, 0, 0, 32'h12345678);
    checks++; if (mis !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL lh_odd_err got=%b/%h exp=1/0", mis, rd); end
    checks++; if (req_cnt !== 0 || lat !== 1) begin failures++; $display("FAIL lh_odd_noreq got=%0d/%0d exp=0/1", req_cnt, lat); end

    do_access(1'b0, OP_W, 32'h202, 32'h0, 0, 0, 32'h12345678);
    checks++; if (mis !== 1'b1 || req_cnt !== 0) begin failures++; $display("FAIL lw_202_err got=%b/%0d exp=1/0", mis, req_cnt); end

    do_access(1'b1, OP_BU, 32'h100, 32'h55, 0, 0, 32'h0);
    checks++; if (mis !== 1'b1 || req_cnt !== 0) begin failures++; $display("FAIL store_bu_err got=%b/%0d exp=1/0", mis, req_cnt); end

    do_access(1'b0, OP_NONE, 32'h100, 32'h0, 0, 0, 32'h0);
    checks++; if (mis !== 1'b1 || req_cnt !== 0) begin failures++; $display("FAIL op_none_err got=%b/%0d exp=1/0", mis, req_cnt); end

    do_access(1'b1, OP_H, 32'h100, 32'h0000BEEF, 0, 0, 32'h0);
    checks++; if (mis !== 1'b0 || mk !== 4'b0011 || mwd !== 32'hBEEFBEEF) begin failures++; $display("FAIL sh_low got=%b/%b/%h exp=0/0011/beefbeef", mis, mk, mwd); end
  endtask

  task automatic test_slow_handshake();
    do_access(1'b0, OP_W, 32'h200, 32'h0, 3, 2, 32'hCAFEF00D);
    checks++; if (lat !== 8) begin failures++; $display("FAIL slow_latency got=%0d exp=8", lat); end
    checks++; if (sok !== 1'b1) begin failures++; $display("FAIL slow_stall got=%b exp=1", sok); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL slow_done_count got=%0d exp=1", done_cnt); end
    checks++; if (req_cnt !== 4 || madr !== 32'h200) begin failures++; $display("FAIL slow_req got=%0d/%h exp=4/00000200", req_cnt, madr); end
    checks++; if (rd !== 32'hCAFEF00D) begin failures++; $display("FAIL slow_rdata got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_reset_abort();
    logic no_done = 1'b1;
    req_valid = 1'b1; req_wr = 1'b0; req_op = OP_W; addr = 32'h300;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h11111111;
    step();
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL abort_req_up got=%b exp=1", mem_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL abort_req_async got=%b exp=0", mem_req); end
    req_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    req_valid = 1'b1;
    step();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL abort_wait got=%b/%b exp=0/0", mem_req, done); end
    step();
    rst_n = 1'b1;
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0) no_done = 1'b0;
      step();
    end
    checks++; if (no_done !== 1'b1 || rdata !== 32'h0) begin failures++; $display("FAIL abort_no_done got=%b/%h exp=1/0", no_done, rdata); end

    do_access(1'b0, OP_W, 32'h304, 32'h0, 0, 0, 32'h0BADF00D);
    checks++; if (lat !== 3 || rd !== 32'h0BADF00D || done_cnt !== 1) begin failures++; $display("FAIL abort_recover got=%0d/%h/%0d exp=3/0badf00d/1", lat, rd, done_cnt); end
  endtask

  initial begin
    test_reset();
    test_store();
    test_load();
    test_misalign();
    test_slow_handshake();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter WIDTH, default 32, data/address width.
REQ-002 clk  in  1  sole clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req_valid  in  1  current instruction is a load or store; held stable while stall=1.
REQ-005 req_wr  in  1  1=store, 0=load.
REQ-006 req_op  in  3  MemOP: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu, 111 none.
REQ-007 addr  in  WIDTH  effective byte address from ALU.
REQ-008 wdata  in  WIDTH  store data (rs2).
REQ-009 stall  out  1  hold PC and register write.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 rdata  out  WIDTH  extended load result, valid when done=1.
REQ-012 misalign  out  1  access error, valid when done=1.
REQ-013 mem_req  out  1  memory request.
REQ-014 mem_we  out  1  memory write enable.
REQ-015 mem_addr  out  WIDTH  word-aligned address (addr[1:0] forced 00).
REQ-016 mem_wmask  out  4  byte-lane write strobes.
REQ-017 mem_wdata  out  WIDTH  lane-replicated store data.
REQ-018 mem_gnt  in  1  memory accepts request.
REQ-019 mem_rvalid  in  1  load data valid.
REQ-020 mem_rdata  in  WIDTH  aligned memory word.

Function
REQ-021 FSM states IDLE, REQ, WAIT, RESP.
REQ-022 IDLE, req_valid=1: latch addr/op/wr/wdata; go REQ, or RESP with error flag if misaligned.
REQ-023 Misaligned: op 001/101 with addr[0]=1; op 010 with addr[1:0]!=00; op 111; store with op 100/101.
REQ-024 REQ: mem_req=1, outputs stable until mem_gnt; gnt: store -> RESP, load -> WAIT.
REQ-025 WAIT: mem_rvalid sampled only here; on rvalid latch extracted data, go RESP.
REQ-026 RESP: done=1 one cycle, then IDLE; req_valid ignored in RESP (same instruction).
REQ-027 stall = req_valid & (state != RESP).
REQ-028 Min latency: store done 2 cycles after acceptance, load 3 cycles (gnt and rvalid immediate).
REQ-029 Store mask: byte 0001<<addr[1:0]; half 0011 if addr[1]=0 else 1100; word 1111.
REQ-030 Store data: byte replicated x4, half replicated x2, word as-is.
REQ-031 Load: lane by addr[1:0]/addr[1]; 000/001 sign-extend, 100/101 zero-extend, 010 full word.
REQ-032 Error access: no mem_req, rdata=0, misalign=1 with done.
REQ-033 mem_we=0 and mem_wmask=0000 whenever mem_req=0 or load.
REQ-034 Unlimited gnt/rvalid wait; no timeout.

Reset
REQ-035 rst_n=0: state IDLE, done/misalign/mem_req/mem_we=0, rdata=0, mem_wmask=0, latches 0, immediately.
REQ-036 Reset mid-transaction aborts silently: no done, mem_req drops asynchronously.

Structure
REQ-037 Shared package holds MemOP encodings and FSM state enum.
REQ-038 Combinational sub-module lsu_align: mask, store replication, load extract/extend.

Verification
REQ-039 sw addr=0x100 wdata=0xDEADBEEF, gnt immediate -> mem_wmask=1111, mem_addr=0x100, done 2 cycles later.
REQ-040 lb addr=0x103, mem_rdata=0x80FF7F01 -> rdata=0xFFFFFF80; lbu -> 0x00000080.
REQ-041 sh addr=0x102 wdata=0x1234 -> wmask=1100, mem_wdata=0x12341234; lh addr=0x101 -> misalign=1, no mem_req.
REQ-042 lw addr=0x200, gnt after 3 cycles, rvalid after 2 more -> stall held throughout, done once, rdata=mem_rdata.
REQ-043 rst_n low in WAIT -> mem_req=0, no done; next lw completes normally.
